// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: opcodes, FSM states
// and default latencies.
package md_pkg;

    // MD opcode encoding carried by op_e from the E stage
    localparam logic [2:0] MD_NONE = 3'd0;
    localparam logic [2:0] MULT    = 3'd1;
    localparam logic [2:0] MULTU   = 3'd2;
    localparam logic [2:0] DIV     = 3'd3;
    localparam logic [2:0] DIVU    = 3'd4;
    localparam logic [2:0] MTHI    = 3'd5;
    localparam logic [2:0] MTLO    = 3'd6;
    localparam logic [2:0] MFHI    = 3'd7;

    // Default busy-window lengths and counter width
    localparam int DEF_MUL_LAT = 5;
    localparam int DEF_DIV_LAT = 10;
    localparam int DEF_CNT_W   = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    // True for the opcodes that occupy the unit for a multi-cycle window
    function automatic logic is_start_op(input logic [2:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/md_core.sv
// Combinational multiply/divide datapath: produces the 64-bit {hi, lo}
// result for the given opcode and flags a divide by zero.
module md_core
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res,
    output logic        div0
);

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] b_safe;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;

    assign a_sx   = {{32{a[31]}}, a};
    assign b_sx   = {{32{b[31]}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a} * {32'd0, b};

    // A zero divisor is replaced by one so the dividers never see /0; the
    // result is discarded upstream via div0 anyway.
    assign b_safe = (b == 32'd0) ? 32'd1 : b;
    assign a_s    = a;
    assign b_s    = b_safe;
    assign quot_s = a_s / b_s;
    assign rem_s  = a_s % b_s;
    assign quot_u = a / b_safe;
    assign rem_u  = a % b_safe;

    assign div0 = (b == 32'd0) && ((op == DIV) || (op == DIVU));

    // Select the result layout: products are {hi, lo}; divides are {rem, quot}
    always_comb begin
        res = 64'd0;
        case (op)
            MULT:    res = prod_s;
            MULTU:   res = prod_u;
            DIV:     res = {rem_s, quot_s};
            DIVU:    res = {rem_u, quot_u};
            default: res = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide sequencer: owns HI/LO, runs the fixed-latency busy window
// for mult/div, and raises the D-stage stall for MD-class instructions.
module md_sched
    import md_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  op_e,
    input  logic [31:0] rs_e,
    input  logic [31:0] rt_e,
    input  logic        md_in_d,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t         state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [31:0]       pend_hi_reg, pend_hi_next;
    logic [31:0]       pend_lo_reg, pend_lo_next;
    logic              pend_skip_reg, pend_skip_next;
    logic [31:0]       hi_reg, hi_next;
    logic [31:0]       lo_reg, lo_next;

    logic [63:0]       core_res;
    logic              core_div0;

    md_core u_core (
        .op   (op_e),
        .a    (rs_e),
        .b    (rt_e),
        .res  (core_res),
        .div0 (core_div0)
    );

    // State, counter, pending result and architectural HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            pend_hi_reg   <= '0;
            pend_lo_reg   <= '0;
            pend_skip_reg <= 1'b0;
            hi_reg        <= '0;
            lo_reg        <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            pend_hi_reg   <= pend_hi_next;
            pend_lo_reg   <= pend_lo_next;
            pend_skip_reg <= pend_skip_next;
            hi_reg        <= hi_next;
            lo_reg        <= lo_next;
        end
    end

    // Next-state: accept ops only in IDLE; commit the pending result when the
    // countdown expires (a divide by zero leaves HI/LO untouched).
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        pend_hi_next   = pend_hi_reg;
        pend_lo_next   = pend_lo_reg;
        pend_skip_next = pend_skip_reg;
        hi_next        = hi_reg;
        lo_next        = lo_reg;
        case (state_reg)
            ST_IDLE: begin
                if (is_start_op(op_e)) begin
                    state_next     = ST_BUSY;
                    cnt_next       = ((op_e == MULT) || (op_e == MULTU)) ?
                                     CNT_W'(MUL_LAT - 1) : CNT_W'(DIV_LAT - 1);
                    pend_hi_next   = core_res[63:32];
                    pend_lo_next   = core_res[31:0];
                    pend_skip_next = core_div0;
                end else if (op_e == MTHI) begin
                    hi_next = rs_e;
                end else if (op_e == MTLO) begin
                    lo_next = rs_e;
                end
            end
            ST_BUSY: begin
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                    if (!pend_skip_reg) begin
                        hi_next = pend_hi_reg;
                        lo_next = pend_lo_reg;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy     = (state_reg == ST_BUSY);
    assign md_stall = md_in_d & (busy | is_start_op(op_e));
    assign hi       = hi_reg;
    assign lo       = lo_reg;

endmodule
